// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the four-way bus arbiter and its requesters.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    OWN,
    RELEASE
  } req_state_t;

  localparam int unsigned BUS_MAX_WAIT = 15;
  localparam int unsigned BUS_LEN_W    = 4;

  // Width of a counter that must hold 0 .. max_wait-1; never narrower than 1 bit.
  function automatic int unsigned wait_cnt_w(input int unsigned max_wait);
    return (max_wait > 1) ? $clog2(max_wait) : 1;
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Clear/enable wait counter with a terminal-count flag at MAX_WAIT-1.
module bus_wait_timer
  import bus_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = BUS_MAX_WAIT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = wait_cnt_w(MAX_WAIT);
  localparam logic [CntW-1:0] TcVal = CntW'(MAX_WAIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TcVal);

endmodule

// File: rtl/bus_requester.sv
// Master-side bus agent: requests the bus, waits a bounded time for grant,
// transfers a burst (surviving preemption) and reports done or timeout.
module bus_requester
  import bus_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = BUS_MAX_WAIT,
  parameter int unsigned LEN_W    = BUS_LEN_W
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_grant,
  output logic             o_request,
  output logic             o_bus_en,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout
);

  localparam logic [LEN_W:0] OneBeat = (LEN_W + 1)'(1);

  req_state_t     state_q, state_d;
  logic [LEN_W:0] beats_q, beats_d;
  logic           err_q, err_d;
  logic           timer_clr, timer_en, wait_tc;

  bus_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .clk_i (Clock),
    .rst_ni(Resetn),
    .clr_i (timer_clr),
    .en_i  (timer_en),
    .tc_o  (wait_tc)
  );

  // Next-state logic for the FSM, beat counter, error flag and wait timer control.
  always_comb begin
    state_d   = state_q;
    beats_d   = beats_q;
    err_d     = err_q;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          beats_d   = {1'b0, i_len} + OneBeat;
          err_d     = 1'b0;
          timer_clr = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (i_grant) begin
          state_d = OWN;
        end else if (wait_tc) begin
          err_d   = 1'b1;
          state_d = RELEASE;
        end else begin
          timer_en = 1'b1;
        end
      end
      OWN: begin
        if (i_grant) begin
          if (beats_q == OneBeat) begin
            state_d = RELEASE;
          end else begin
            beats_d = beats_q - OneBeat;
          end
        end else begin
          // Preempted: beat not counted, wait window restarts from zero.
          timer_clr = 1'b1;
          state_d   = REQ;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      beats_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      err_q   <= err_d;
    end
  end

  // Moore outputs decoded from registered state only.
  always_comb begin
    o_request = (state_q == REQ) || (state_q == OWN);
    o_bus_en  = (state_q == OWN);
    o_busy    = (state_q != IDLE);
    o_done    = (state_q == RELEASE) && !err_q;
    o_timeout = (state_q == RELEASE) && err_q;
  end

endmodule

// File: tb/tb_bus_requester.sv
// Self-checking bench for bus_requester: directed scenarios plus randomized
// grant patterns checked cycle by cycle against a transaction-level model.
module tb_bus_requester;

  localparam int MAXW = 15;
  localparam int LENW = 4;

  logic            Clock = 1'b0;
  logic            Resetn;
  logic            i_start;
  logic [LENW-1:0] i_len;
  logic            i_grant;
  logic            o_request, o_bus_en, o_busy, o_done, o_timeout;
  logic [4:0]      obs;

  int n_tests = 0;
  int n_fail  = 0;

  // Grant value driven during each cycle of a burst, and expected outputs
  // {request, bus_en, busy, done, timeout} for those cycles.
  bit         gpat[0:255];
  logic [4:0] exp_v[0:299];
  int         exp_n;

  localparam logic [4:0] VIdle = 5'b00000;
  localparam logic [4:0] VWait = 5'b10100;
  localparam logic [4:0] VOwn  = 5'b11100;
  localparam logic [4:0] VDone = 5'b00110;
  localparam logic [4:0] VTout = 5'b00101;

  bus_requester #(
    .MAX_WAIT(MAXW),
    .LEN_W   (LENW)
  ) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .i_start  (i_start),
    .i_len    (i_len),
    .i_grant  (i_grant),
    .o_request(o_request),
    .o_bus_en (o_bus_en),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_timeout(o_timeout)
  );

  always #5 Clock = ~Clock;

  assign obs = {o_request, o_bus_en, o_busy, o_done, o_timeout};

  task automatic check(input string tag, input logic [4:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %b required %b", tag, $time, obs, expv);
    end
  endtask

  // Grant patterns: 0 always, 1 never, 2 mostly granted, 3 rarely granted.
  // Past index 200 the grant is always high so every burst ends.
  task automatic fill_grants(input int mode);
    for (int i = 0; i < 256; i++) begin
      if (i >= 200) gpat[i] = 1'b1;
      else begin
        case (mode)
          0:       gpat[i] = 1'b1;
          1:       gpat[i] = 1'b0;
          2:       gpat[i] = ($urandom_range(3) != 0);
          default: gpat[i] = ($urandom_range(3) == 0);
        endcase
      end
    end
  endtask

  // Transaction-level model: alternate bounded wait windows and ownership
  // runs until all beats are transferred or a window expires.
  task automatic build_model(input int len);
    int c, beats, w;
    bit finished, got, lost;
    c = 0;
    beats = len + 1;
    finished = 1'b0;
    while (!finished) begin
      got = 1'b0;
      w = 0;
      while (w < MAXW && !got) begin
        exp_v[c] = VWait;
        got = gpat[c];
        c++;
        w++;
      end
      if (!got) begin
        exp_v[c] = VTout;
        c++;
        finished = 1'b1;
      end else begin
        lost = 1'b0;
        while (!lost && beats > 0) begin
          exp_v[c] = VOwn;
          if (gpat[c]) beats--;
          else lost = 1'b1;
          c++;
        end
        if (beats == 0) begin
          exp_v[c] = VDone;
          c++;
          finished = 1'b1;
        end
      end
    end
    exp_n = c;
  endtask

  // Entered and left at posedge+1 of an IDLE cycle. Command inputs are
  // scrambled while busy since they must be ignored outside IDLE.
  task automatic run_burst(input string tag, input int len);
    i_start = 1'b1;
    i_len   = LENW'(len);
    i_grant = 1'b0;
    @(negedge Clock);
    check({tag, "_idle"}, VIdle);
    @(posedge Clock);
    #1;
    build_model(len);
    for (int c = 0; c < exp_n; c++) begin
      i_grant = gpat[c];
      i_start = 1'($urandom);
      i_len   = LENW'($urandom);
      @(negedge Clock);
      check(tag, exp_v[c]);
      @(posedge Clock);
      #1;
    end
    i_start = 1'b0;
    i_grant = 1'b0;
  endtask

  initial begin
    Resetn  = 1'b0;
    i_start = 1'b1;
    i_len   = 4'd3;
    i_grant = 1'b1;
    #1;
    check("rst_async", VIdle);
    repeat (3) begin
      @(negedge Clock);
      check("rst_hold", VIdle);
    end
    @(posedge Clock);
    #1;
    Resetn  = 1'b1;
    i_start = 1'b0;
    repeat (3) begin
      @(negedge Clock);
      check("idle_no_start", VIdle);
    end
    @(posedge Clock);
    #1;

    fill_grants(0);
    run_burst("len3_grant", 3);

    fill_grants(1);
    run_burst("len0_timeout", 0);

    // Two beats, three cycles preempted, then the remaining four beats.
    fill_grants(0);
    gpat[3] = 1'b0;
    gpat[4] = 1'b0;
    gpat[5] = 1'b0;
    run_burst("len5_preempt", 5);

    // Reset during beat 3 of a 6-beat burst.
    fill_grants(0);
    i_start = 1'b1;
    i_len   = 4'd5;
    i_grant = 1'b1;
    @(negedge Clock);
    check("mid_idle", VIdle);
    @(posedge Clock);
    #1;
    i_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      check("mid_run", (k == 0) ? VWait : VOwn);
      if (k < 3) begin
        @(posedge Clock);
        #1;
      end
    end
    #2;
    Resetn = 1'b0;
    #1;
    check("mid_rst_async", VIdle);
    @(posedge Clock);
    #1;
    check("mid_rst_hold", VIdle);
    @(negedge Clock);
    Resetn = 1'b1;
    @(posedge Clock);
    #1;
    check("mid_rst_after", VIdle);
    i_grant = 1'b0;
    fill_grants(0);
    run_burst("after_rst_len1", 1);

    // Back-to-back commands with grant always high.
    fill_grants(0);
    for (int b = 0; b < 4; b++) run_burst("b2b", b);

    for (int r = 0; r < 30; r++) begin
      fill_grants(2 + (r % 2));
      run_burst("rand", int'($urandom_range(15)));
    end

    @(negedge Clock);
    check("final_idle", VIdle);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
